inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
// Fetch-side initiator for inst_cache: drives the cache address (ptr), samples out/hit, and
// buffers returned instructions with their PCs in a small FIFO for decode via valid/ready.
// Holds ptr across cache misses, counts miss stall cycles, and flushes on branch redirect.
// Sits between inst_cache and the decode stage of the CPU pipeline.
// PARAMETERS
// WORD_SIZE  32  datapath/address width (from parameters.v)
// BUF_DEPTH  4   fetch FIFO entries; power of 2, >= 2
// RESET_PC   0   word address fetched first after reset
// PORTS
// clk          in   1          clock; all state updates on posedge
// rst          in   1          synchronous, active-high reset
// ptr          out  WORD_SIZE  word address presented to inst_cache
// ic_out       in   WORD_SIZE  instruction word from inst_cache for current ptr
// ic_hit       in   1          inst_cache hit for current ptr (same cycle as ptr)
// redirect     in   1          branch/jump redirect request
// redirect_pc  in   WORD_SIZE  new fetch word address when redirect=1
// inst         out  WORD_SIZE  instruction at FIFO head; 0 when empty
// inst_pc      out  WORD_SIZE  word address of inst; 0 when empty
// inst_valid   out  1          FIFO non-empty
// inst_ready   in   1          decode accepts head this cycle
// in_miss      out  1          FSM is in MISS
// miss_cycles  out  16         saturating count of cycles spent with ic_hit=0 while fetching
// BEHAVIOUR
// - Reset (rst=1 at posedge): ptr=RESET_PC, FIFO empty, inst_valid=0, inst=0, inst_pc=0,
//   state=RUN, in_miss=0, miss_cycles=0. Reset overrides redirect and every other input.
// - ptr is a register; inst_cache is combinational on ptr, so ic_out/ic_hit are sampled
//   the same cycle ptr is presented.
// - pop = inst_valid & inst_ready. can_push = (count < BUF_DEPTH) | pop.
// - FSM states RUN, MISS (priority order per cycle: rst, redirect, normal):
//   redirect: FIFO flushed (count=0, pop ignored), ptr<=redirect_pc, state<=RUN, no push,
//     miss_cycles unchanged.
//   RUN,  ic_hit=1, can_push: push {ptr, ic_out}; ptr<=ptr+1; stay RUN.
//   RUN,  ic_hit=1, !can_push: hold ptr, no push, stay RUN (backpressure, not a miss).
//   RUN,  ic_hit=0: hold ptr; state<=MISS; miss_cycles+1.
//   MISS, ic_hit=0: hold ptr; miss_cycles+1.
//   MISS, ic_hit=1: state<=RUN; push/advance exactly as RUN with ic_hit=1.
// - miss_cycles increments in RUN/MISS only while ic_hit=0, regardless of can_push;
//   saturates at 16'hFFFF.
// - Latency: instruction at ptr with hit is at FIFO head (inst_valid=1) the next cycle if
//   the FIFO was empty. Sustained throughput 1 instr/cycle with inst_ready=1.
// - Simultaneous push and pop on a full FIFO allowed; count unchanged, order preserved.
// - ptr+1 wraps modulo 2^WORD_SIZE (all-ones -> 0). Pointers of FIFO wrap modulo BUF_DEPTH.
// - FIFO strictly in-order; inst/inst_pc from head entry, registered storage, no bypass.
// TESTING
// 1 rst then ic_hit=1, ic_out=ptr+100, inst_ready=1 -> inst_pc 0,1,2,... inst 100,101,...
//   one per cycle; first inst_valid one cycle after ptr=0 presented.
// 2 inst_ready=0, ic_hit=1 -> 4 pushes, ptr stalls at 4, inst_valid=1, miss_cycles=0; then
//   inst_ready=1 -> inst_pc 0,1,2,3,4,5 with no gap or duplicate.
// 3 ic_hit=0 for 3 cycles at ptr=2 -> ptr holds 2, in_miss=1 for those cycles,
//   miss_cycles=3; hit returns -> entry pc=2 pushed, ptr=3, in_miss=0.
// 4 FIFO holds 3 entries, redirect=1 redirect_pc=17 -> next cycle inst_valid=0, ptr=17;
//   following cycle inst_pc=17; simultaneous pop that cycle dropped.
// 5 rst asserted mid-MISS with 2 buffered entries -> next cycle ptr=RESET_PC, inst_valid=0,
//   in_miss=0, miss_cycles=0.
// 6 redirect_pc=32'hFFFFFFFF, ic_hit=1 -> inst_pc FFFFFFFF then 00000000; miss_cycles
//   forced near 16'hFFFF with ic_hit=0 holds at FFFF.

Source files
------------

// File: rtl/inst_fetch.sv
// Fetch initiator for inst_cache: presents ptr, captures hits into an in-order FIFO for decode,
// holds ptr across misses (counting stall cycles) and flushes on branch redirect.
module inst_fetch #(
   parameter int                    WORD_SIZE = 32,
   parameter int                    BUF_DEPTH = 4,
   parameter logic [WORD_SIZE-1:0]  RESET_PC  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [WORD_SIZE-1:0]  ptr,
   input  logic [WORD_SIZE-1:0]  ic_out,
   input  logic                  ic_hit,
   input  logic                  redirect,
   input  logic [WORD_SIZE-1:0]  redirect_pc,
   output logic [WORD_SIZE-1:0]  inst,
   output logic [WORD_SIZE-1:0]  inst_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic                  in_miss,
   output logic [15:0]           miss_cycles
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);

   typedef struct packed {
      logic [WORD_SIZE-1:0] pc;
      logic [WORD_SIZE-1:0] ins;
   } fetch_ent_t;

   typedef enum logic {RUN, MISS} state_t;

   state_t                      state, state_nxt;
   fetch_ent_t [BUF_DEPTH-1:0]  buf_q;
   logic [AW-1:0]               rd_ptr, wr_ptr;
   logic [AW:0]                 count;
   logic                        pop, can_push, push, miss_inc;

   assign inst_valid = (count != '0);
   assign inst       = inst_valid ? buf_q[rd_ptr].ins : '0;
   assign inst_pc    = inst_valid ? buf_q[rd_ptr].pc  : '0;
   assign in_miss    = (state == MISS);
   assign pop        = inst_valid & inst_ready;
   // A pop this cycle frees a slot, so a full FIFO can still accept a push.
   assign can_push   = (count < DEPTH_C) | pop;

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      miss_inc  = 1'b0;
      if (redirect) begin
         state_nxt = RUN;
      end else begin
         case (state)
            RUN, MISS: begin
               if (ic_hit) begin
                  state_nxt = RUN;
                  push      = can_push;
               end else begin
                  state_nxt = MISS;
                  miss_inc  = 1'b1;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         miss_cycles <= '0;
      end else if (redirect) begin
         ptr    <= redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            ptr    <= ptr + WORD_SIZE'(1);
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (miss_inc && miss_cycles != 16'hFFFF) miss_cycles <= miss_cycles + 16'd1;
      end
   end

   // Storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (!rst && !redirect && push) buf_q[wr_ptr] <= '{pc: ptr, ins: ic_out};
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized and directed checks of inst_fetch against a queue-based reference model of
// the fetch FIFO, ptr, miss state and saturating miss counter.
module tb_inst_fetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, ic_hit, redirect, inst_ready;
   logic [31:0] ptr, ic_out, redirect_pc, inst, inst_pc;
   logic        inst_valid, in_miss;
   logic [15:0] miss_cycles;
   logic [31:0] salt = 32'd0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_ptr;
   bit          m_miss;
   int          m_mc;

   always #5 clk = ~clk;

   // Combinational cache stand-in: word at address a is a + 100 + salt.
   assign ic_out = ptr + 32'd100 + salt;

   inst_fetch #(.WORD_SIZE(32), .BUF_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
      .clk(clk), .rst(rst), .ptr(ptr), .ic_out(ic_out), .ic_hit(ic_hit),
      .redirect(redirect), .redirect_pc(redirect_pc), .inst(inst), .inst_pc(inst_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .in_miss(in_miss),
      .miss_cycles(miss_cycles)
   );

   // One clock with the given inputs; advances the reference model, samples 1ns later.
   task automatic step(input bit r, input bit h, input bit rd, input logic [31:0] rpc,
                       input bit rdy);
      rst = r; ic_hit = h; redirect = rd; redirect_pc = rpc; inst_ready = rdy;
      @(posedge clk);
      if (r) begin
         m_ptr = 32'd0; mq.delete(); m_miss = 1'b0; m_mc = 0;
      end else if (rd) begin
         mq.delete(); m_ptr = rpc; m_miss = 1'b0;
      end else begin
         if (mq.size() > 0 && rdy) void'(mq.pop_front());
         if (h) begin
            m_miss = 1'b0;
            if (mq.size() < DEPTH) begin
               mq.push_back('{pc: m_ptr, ins: m_ptr + 32'd100 + salt});
               m_ptr = m_ptr + 32'd1;
            end
         end else begin
            m_miss = 1'b1;
            if (m_mc < 65535) m_mc++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      step(1, 1, 1, 32'd77, 1);
      step(1, 0, 0, 32'd0, 0);
      checks++;
      if (ptr !== 32'd0 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0 ||
          in_miss !== 1'b0 || miss_cycles !== 16'd0) begin
         errors++;
         $display("FAIL reset: ptr=%h valid=%b inst=%h pc=%h miss=%b mc=%h, want all 0",
                  ptr, inst_valid, inst, inst_pc, in_miss, miss_cycles);
      end
   endtask

   task automatic test_stream();
      step(1, 0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         step(0, 1, 0, 0, 1);
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'(k-1) || inst !== 32'(k-1+100)) begin
            errors++;
            $display("FAIL stream[%0d]: valid=%b pc=%0d inst=%0d, want 1 %0d %0d",
                     k, inst_valid, inst_pc, inst, k-1, k-1+100);
         end
      end
   endtask

   task automatic test_backpressure();
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0);
      checks++;
      if (ptr !== 32'd4 || inst_valid !== 1'b1 || inst_pc !== 32'd0 || miss_cycles !== 16'd0) begin
         errors++;
         $display("FAIL bp_full: ptr=%0d valid=%b pc=%0d mc=%0d, want 4 1 0 0",
                  ptr, inst_valid, inst_pc, miss_cycles);
      end
      for (int j = 1; j <= 5; j++) begin
         step(0, 1, 0, 0, 1);
         checks++;
         if (inst_pc !== 32'(j) || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain[%0d]: pc=%0d valid=%b, want %0d 1", j, inst_pc, inst_valid, j);
         end
      end
   endtask

   task automatic test_miss();
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 0, 0, 1);
         checks++;
         if (ptr !== 32'd2 || in_miss !== 1'b1 || miss_cycles !== 16'(i)) begin
            errors++;
            $display("FAIL miss[%0d]: ptr=%0d in_miss=%b mc=%0d, want 2 1 %0d",
                     i, ptr, in_miss, miss_cycles, i);
         end
      end
      step(0, 1, 0, 0, 0);
      checks++;
      if (ptr !== 32'd3 || in_miss !== 1'b0 || inst_pc !== 32'd2 || inst !== 32'd102 ||
          miss_cycles !== 16'd3) begin
         errors++;
         $display("FAIL miss_exit: ptr=%0d in_miss=%b pc=%0d inst=%0d mc=%0d, want 3 0 2 102 3",
                  ptr, in_miss, inst_pc, inst, miss_cycles);
      end
   endtask

   task automatic test_redirect();
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 32'd17, 1);
      checks++;
      if (inst_valid !== 1'b0 || ptr !== 32'd17 || inst !== 32'd0) begin
         errors++;
         $display("FAIL redirect: valid=%b ptr=%0d inst=%0d, want 0 17 0", inst_valid, ptr, inst);
      end
      step(0, 1, 0, 0, 0);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd17 || inst !== 32'd117) begin
         errors++;
         $display("FAIL redirect_head: valid=%b pc=%0d inst=%0d, want 1 17 117",
                  inst_valid, inst_pc, inst);
      end
   endtask

   task automatic test_reset_mid_miss();
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      checks++;
      if (in_miss !== 1'b1 || miss_cycles !== 16'd2) begin
         errors++;
         $display("FAIL pre_rst_miss: in_miss=%b mc=%0d, want 1 2", in_miss, miss_cycles);
      end
      step(1, 1, 1, 32'd55, 1);
      checks++;
      if (ptr !== 32'd0 || inst_valid !== 1'b0 || in_miss !== 1'b0 || miss_cycles !== 16'd0) begin
         errors++;
         $display("FAIL rst_mid_miss: ptr=%0d valid=%b in_miss=%b mc=%0d, want 0 0 0 0",
                  ptr, inst_valid, in_miss, miss_cycles);
      end
   endtask

   task automatic test_wrap();
      step(0, 0, 1, 32'hFFFF_FFFF, 0);
      step(0, 1, 0, 0, 1);
      checks++;
      if (inst_pc !== 32'hFFFF_FFFF || inst !== 32'd99 || ptr !== 32'd0) begin
         errors++;
         $display("FAIL wrap0: pc=%h inst=%0d ptr=%h, want ffffffff 99 0", inst_pc, inst, ptr);
      end
      step(0, 1, 0, 0, 1);
      checks++;
      if (inst_pc !== 32'd0 || inst !== 32'd100 || ptr !== 32'd1) begin
         errors++;
         $display("FAIL wrap1: pc=%h inst=%0d ptr=%h, want 0 100 1", inst_pc, inst, ptr);
      end
   endtask

   task automatic test_saturate();
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 65534; i++) step(0, 0, 0, 0, 0);
      checks++;
      if (miss_cycles !== 16'hFFFE) begin
         errors++;
         $display("FAIL sat_pre: mc=%h, want fffe", miss_cycles);
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
      checks++;
      if (miss_cycles !== 16'hFFFF || in_miss !== 1'b1) begin
         errors++;
         $display("FAIL sat_hold: mc=%h in_miss=%b, want ffff 1", miss_cycles, in_miss);
      end
      step(0, 1, 0, 0, 1);
      checks++;
      if (miss_cycles !== 16'hFFFF || in_miss !== 1'b0) begin
         errors++;
         $display("FAIL sat_exit: mc=%h in_miss=%b, want ffff 0", miss_cycles, in_miss);
      end
   endtask

   task automatic test_random();
      logic [31:0] rpc, exp_inst, exp_pc;
      bit          exp_valid;
      salt = $urandom;
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 2000; i++) begin
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE - 32'($urandom_range(0, 2))) : $urandom;
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) < 6);
         exp_valid = (mq.size() != 0);
         exp_inst  = exp_valid ? mq[0].ins : 32'd0;
         exp_pc    = exp_valid ? mq[0].pc  : 32'd0;
         checks++;
         if (ptr !== m_ptr || inst_valid !== exp_valid || inst !== exp_inst ||
             inst_pc !== exp_pc || in_miss !== m_miss || miss_cycles !== 16'(m_mc)) begin
            errors++;
            $display("FAIL random[%0d]: ptr=%h/%h valid=%b/%b inst=%h/%h pc=%h/%h miss=%b/%b mc=%0d/%0d (got/want)",
                     i, ptr, m_ptr, inst_valid, exp_valid, inst, exp_inst, inst_pc, exp_pc,
                     in_miss, m_miss, miss_cycles, m_mc);
         end
      end
   endtask

   initial begin
      rst = 1'b1; ic_hit = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_miss();
      test_redirect();
      test_reset_mid_miss();
      test_wrap();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
